// File: rtl/seq_mag_comparator_pkg.sv
// rtl/seq_mag_comparator_pkg.sv - shared FSM encoding, flag positions and sizing helper
package seq_mag_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Result flag bit positions follow the board LED ordering.
  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;
  localparam int NFLAG   = 3;

  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/seq_mag_comparator_slice_compare.sv
// rtl/seq_mag_comparator_slice_compare.sv - combinational unsigned compare of one slice
module slice_compare #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_s,
  input  logic [DIGIT-1:0] b_s,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a_s > b_s);
  assign eq = (a_s == b_s);
  assign lt = (a_s < b_s);

endmodule

// File: rtl/seq_mag_comparator.sv
// rtl/seq_mag_comparator.sv - slice-serial magnitude comparator, MSB slice first with early exit
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] TOP_IDX = IW'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sm_q, sm_d;
  logic [NFLAG-1:0] res_q, res_d;

  logic [DIGIT-1:0] a_sl, b_sl;
  logic             s_gt, s_eq, s_lt;

  // Flipping both sign bits in the top slice turns a signed compare into an unsigned one.
  always_comb begin
    int lo;
    lo   = int'(idx_q) * DIGIT;
    a_sl = DIGIT'(a_q >> lo);
    b_sl = DIGIT'(b_q >> lo);
    if (sm_q && (idx_q == TOP_IDX)) begin
      a_sl[DIGIT-1] = ~a_sl[DIGIT-1];
      b_sl[DIGIT-1] = ~b_sl[DIGIT-1];
    end
  end

  slice_compare #(.DIGIT(DIGIT)) u_slice (
    .a_s (a_sl),
    .b_s (b_sl),
    .gt  (s_gt),
    .eq  (s_eq),
    .lt  (s_lt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          idx_d   = TOP_IDX;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!s_eq) begin
          res_d          = '0;
          res_d[FLAG_GT] = s_gt;
          res_d[FLAG_LT] = s_lt;
          state_d        = ST_DONE;
        end else if (idx_q == '0) begin
          res_d          = '0;
          res_d[FLAG_EQ] = 1'b1;
          state_d        = ST_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q == ST_SCAN);
  assign done = (state_q == ST_DONE);
  assign gt   = res_q[FLAG_GT];
  assign eq   = res_q[FLAG_EQ];
  assign lt   = res_q[FLAG_LT];

endmodule
